// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// quotient returned on a zero divisor.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath on the {acc, opr} pair:
// shift-add (right shift) for multiply, restoring shift-subtract for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opr_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, b_i};
    shifted = {acc_i, opr_i[WIDTH-1]};
    // When the subtract succeeds the true difference is below b, so W bits suffice.
    diff    = shifted[WIDTH-1:0] - b_i;
    acc_o   = acc_i;
    opr_o   = opr_i;
    if (is_div_i) begin
      if (shifted >= {1'b0, b_i}) begin
        acc_o = diff;
        opr_o = {opr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        opr_o = {opr_i[WIDTH-2:0], 1'b0};
      end
    end else if (opr_i[0]) begin
      acc_o = sum[WIDTH:1];
      opr_o = {sum[0], opr_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[WIDTH-1:1]};
      opr_o = {acc_i[0], opr_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO.
// Define MDU_SIGNED_EN to build signed MULT/DIV; otherwise they behave as MULTU/DIVU.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Handshake: start (and mthi/mtlo) are taken on a rising edge only while busy=0;
  // done pulses for one cycle with HI/LO already holding the new result.
  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             last_step;
  logic             is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_acc, step_opr;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_step = (state_q == RUN) && (cnt_q == LAST_CNT);
  assign is_div    = (op_q == MDU_DIVU) || (op_q == MDU_DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opr_i    (opr_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .opr_o    (step_opr)
  );

`ifdef MDU_SIGNED_EN
  logic             sgn_op;
  logic             a_neg, b_neg;
  logic             sa_q, sb_q;
  logic [2*WIDTH-1:0] prod_neg;

  assign sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg    = sgn_op && a[WIDTH-1];
  assign b_neg    = sgn_op && b[WIDTH-1];
  assign a_mag    = a_neg ? (~a + 1'b1) : a;
  assign b_mag    = b_neg ? (~b + 1'b1) : b;
  assign prod_neg = ~{step_acc, step_opr} + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (accept) begin
      sa_q <= a_neg;
      sb_q <= b_neg;
    end
  end

  // Quotient/product take sign(a)^sign(b); the remainder follows the dividend.
  always_comb begin
    res_hi = step_acc;
    res_lo = step_opr;
    if (is_div) begin
      if (sa_q ^ sb_q) res_lo = ~step_opr + 1'b1;
      if (sa_q)        res_hi = ~step_acc + 1'b1;
    end else if (sa_q ^ sb_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
    if (is_div && (b_q == '0)) begin
      res_lo = WIDTH'(MDU_DIV0_Q);
      res_hi = a_raw_q;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;

  always_comb begin
    res_hi = step_acc;
    res_lo = step_opr;
    if (is_div && (b_q == '0)) begin
      res_lo = WIDTH'(MDU_DIV0_Q);
      res_hi = a_raw_q;
    end
  end
`endif

  always_comb begin
    acc_d   = acc_q;
    opr_d   = opr_q;
    b_d     = b_q;
    a_raw_d = a_raw_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      acc_d   = '0;
      opr_d   = a_mag;
      b_d     = b_mag;
      a_raw_d = a;
      op_d    = mdu_op_e'(op);
      cnt_d   = '0;
    end else if (busy) begin
      acc_d = step_acc;
      opr_d = step_opr;
      cnt_d = last_step ? '0 : cnt_q + CW'(1);
    end
    // A completing op wins; register writes are only honoured while not busy.
    if (last_step) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (!busy) begin
      if (mthi) hi_d = wd;
      if (mtlo) lo_d = wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opr_q   <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      op_q    <= MDU_MULTU;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      b_q     <= b_d;
      a_raw_q <= a_raw_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
